// File: rtl/cache_ctrl_pkg.sv
// Shared types for the direct-mapped word cache controller.
// Optional statistics counters are enabled with CACHE_STATS_EN.
package cache_ctrl_pkg;

  localparam int INDEX_W = 6;
  localparam int TAG_W   = 10;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } state_e;

  function automatic logic [31:0] pack_word(
    input logic [3:0][7:0] w
  );
    return {w[3], w[2], w[1], w[0]};
  endfunction

endpackage

// File: rtl/cache_controller_if.sv
// CPU request bus and main-memory bus seen by the cache controller.
// master = CPU/memory side, slave = controller side.
interface cache_controller_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

endinterface

// File: rtl/cache_stats.sv
// Hit / miss / writeback event counters for the cache controller.
// Only instantiated when CACHE_STATS_EN is defined.
module cache_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        hit_i,
  input  logic        miss_i,
  input  logic        wb_i,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o,
  output logic [31:0] wb_count_o
);

  logic [31:0] hit_q, miss_q, wb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q  <= '0;
      miss_q <= '0;
      wb_q   <= '0;
    end else begin
      if (hit_i)  hit_q  <= hit_q + 32'd1;
      if (miss_i) miss_q <= miss_q + 32'd1;
      if (wb_i)   wb_q   <= wb_q + 32'd1;
    end
  end

  assign hit_count_o  = hit_q;
  assign miss_count_o = miss_q;
  assign wb_count_o   = wb_q;

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped word cache control FSM: hit/miss, dirty writeback, refill.
// Define CACHE_STATS_EN to add hit_count/miss_count/wb_count outputs.
module cache_controller
  import cache_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  cache_controller_if.slave bus,
  output logic [31:0]     cache_addr,
  output logic [31:0]     cache_data_in,
  output logic            we_cache,
  output logic            set_valid,
  output logic            set_dirty,
  input  logic            cache_hit,
  input  logic            cache_dirty,
  input  logic [3:0][7:0] cache_data_out,
  input  logic [31:0]     memory_write_address
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count,
  output logic [31:0]     wb_count
`endif
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] word;

  assign word = pack_word(cache_data_out);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  // The array rewrites valid/dirty every cycle, so every path sets both.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    valid_d       = valid_q;
    cache_addr    = addr_q;
    cache_data_in = '0;
    we_cache      = 1'b0;
    set_valid     = valid_q;
    set_dirty     = cache_dirty;
    bus.cpu_rdata = '0;
    bus.cpu_ready = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          cache_addr = bus.cpu_addr;
          addr_d     = bus.cpu_addr;
          if (cache_hit) begin
            bus.cpu_ready = 1'b1;
            set_valid     = 1'b1;
            if (bus.cpu_we) begin
              we_cache      = 1'b1;
              cache_data_in = bus.cpu_wdata;
              set_dirty     = 1'b1;
            end else begin
              bus.cpu_rdata = word;
            end
          end else if (cache_dirty) begin
            state_d   = WRITEBACK;
            set_valid = 1'b1;
            set_dirty = 1'b1;
          end else begin
            state_d   = REFILL;
            set_valid = 1'b0;
            set_dirty = 1'b0;
          end
        end
      end
      WRITEBACK: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = memory_write_address;
        bus.mem_wdata = word;
        set_valid     = 1'b1;
        set_dirty     = 1'b1;
        if (bus.mem_ready) state_d = REFILL;
      end
      REFILL: begin
        // Held address keeps the refill on the right line if cpu_req drops.
        bus.mem_req  = 1'b1;
        bus.mem_addr = addr_q;
        set_valid    = 1'b0;
        set_dirty    = 1'b0;
        if (bus.mem_ready) begin
          we_cache      = 1'b1;
          cache_data_in = bus.mem_rdata;
          set_valid     = 1'b1;
          valid_d       = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic miss_ev, wb_ev;

  assign miss_ev = (state_q == IDLE) && bus.cpu_req && !cache_hit;
  assign wb_ev   = (state_q == WRITEBACK) && bus.mem_ready;

  cache_stats u_stats (
    .clk         (clk),
    .reset       (reset),
    .hit_i       (bus.cpu_ready),
    .miss_i      (miss_ev),
    .wb_i        (wb_ev),
    .hit_count_o (hit_count),
    .miss_count_o(miss_count),
    .wb_count_o  (wb_count)
  );
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: array and memory models, scoreboard on cpu_ready.
// Stats outputs are checked when CACHE_STATS_EN is defined.
module tb_cache_controller;
  import cache_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cache_controller_if bus();

  logic [31:0]     cache_addr, cache_data_in, memory_write_address;
  logic            we_cache, set_valid, set_dirty, cache_hit, cache_dirty;
  logic [3:0][7:0] cache_data_out;
`ifdef CACHE_STATS_EN
  logic [31:0]     hit_count, miss_count, wb_count;
`endif

  cache_controller dut (
    .clk                 (clk),
    .reset               (reset),
    .bus                 (bus),
    .cache_addr          (cache_addr),
    .cache_data_in       (cache_data_in),
    .we_cache            (we_cache),
    .set_valid           (set_valid),
    .set_dirty           (set_dirty),
    .cache_hit           (cache_hit),
    .cache_dirty         (cache_dirty),
    .cache_data_out      (cache_data_out),
    .memory_write_address(memory_write_address)
`ifdef CACHE_STATS_EN
    ,
    .hit_count           (hit_count),
    .miss_count          (miss_count),
    .wb_count            (wb_count)
`endif
  );

  // Passive storage array driven only by the controller's strobes
  logic              arr_v [64];
  logic              arr_d [64];
  logic [TAG_W-1:0]  arr_t [64];
  logic [31:0]       arr_w [64];
  logic [INDEX_W-1:0] aidx;
  logic              flush = 1'b1;

  assign aidx = cache_addr[INDEX_W-1:0];

  always_comb begin
    cache_hit   = arr_v[aidx] &&
                  (arr_t[aidx] == cache_addr[INDEX_W+TAG_W-1:INDEX_W]);
    cache_dirty = arr_d[aidx];
    cache_data_out = arr_w[aidx];
    memory_write_address = {16'h0, arr_t[aidx], aidx};
  end

  always @(posedge clk) begin
    arr_v[aidx] <= set_valid;
    arr_d[aidx] <= set_dirty;
    if (we_cache) begin
      arr_w[aidx] <= cache_data_in;
      arr_t[aidx] <= cache_addr[INDEX_W+TAG_W-1:INDEX_W];
    end
    if (flush) begin
      for (int i = 0; i < 64; i++) begin
        arr_v[i] <= 1'b0;
        arr_d[i] <= 1'b0;
        arr_t[i] <= '0;
        arr_w[i] <= '0;
      end
    end
  end

  // Reference model: word-addressed memory contents as the CPU sees them
  logic [31:0] mem_img [logic [31:0]];
  logic [31:0] ref_m   [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] img_rd(input logic [31:0] a);
    return mem_img.exists(a) ? mem_img[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_m.exists(a) ? ref_m[a] : init_val(a);
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sbq [$];
  exp_t mon_e;

  int n_cmp = 0;
  int n_err = 0;
  int n_hit = 0;
  int n_miss = 0;
  int n_wb = 0;
  int n_rf = 0;
  int n_we = 0;
  logic        prev_req = 1'b0;
  logic        ok;
  logic [31:0] cur_addr = '0;
  logic [31:0] last_wb_addr = '0;
  logic [31:0] last_wb_data = '0;
  logic [31:0] last_rf_addr = '0;
  logic [31:0] wexp;

  // Memory responder
  logic mem_hold = 1'b0;
  int   fixed_lat = 3;
  int   lat = 3;
  int   cnt = 0;

  always begin
    @(posedge clk);
    #1;
    if (!mem_hold) begin
      if (reset || bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        cnt = 0;
      end else if (bus.mem_req) begin
        if (cnt >= lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = bus.mem_we ? 32'h0 : img_rd(bus.mem_addr);
          cnt = 0;
          lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(3, 0));
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.cpu_ready) begin
        n_cmp++;
        n_hit++;
        if (sbq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_ready addr=%h", cache_addr);
        end else begin
          mon_e = sbq.pop_front();
          if (mon_e.we)
            ok = we_cache && set_dirty && set_valid && !bus.mem_req &&
                 cache_data_in == mon_e.data && cache_addr == mon_e.addr;
          else
            ok = !we_cache && !bus.mem_req &&
                 bus.cpu_rdata == mon_e.data && cache_addr == mon_e.addr;
          if (!ok) begin
            n_err++;
            $display("FAIL %s addr=%h got rdata=%h wdata=%h we=%b dirty=%b req=%b exp data=%h",
                     mon_e.we ? "store" : "load", mon_e.addr, bus.cpu_rdata,
                     cache_data_in, we_cache, set_dirty, bus.mem_req, mon_e.data);
          end
        end
      end
      if (bus.mem_req && bus.mem_ready && bus.mem_we) begin
        n_cmp++;
        wexp = ref_rd(bus.mem_addr);
        if (bus.mem_wdata !== wexp) begin
          n_err++;
          $display("FAIL writeback addr=%h got=%h exp=%h",
                   bus.mem_addr, bus.mem_wdata, wexp);
        end
        mem_img[bus.mem_addr] = bus.mem_wdata;
        n_wb++;
        last_wb_addr = bus.mem_addr;
        last_wb_data = bus.mem_wdata;
      end
      if (bus.mem_req && bus.mem_ready && !bus.mem_we) begin
        n_cmp++;
        if (bus.mem_addr !== cur_addr) begin
          n_err++;
          $display("FAIL refill_addr got=%h exp=%h", bus.mem_addr, cur_addr);
        end
        n_rf++;
        last_rf_addr = bus.mem_addr;
      end
      if (we_cache) n_we++;
      if (bus.mem_req && !prev_req) n_miss++;
      prev_req = bus.mem_req;
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic do_op(input logic we, input logic [31:0] a,
                       input logic [31:0] d, output int cyc);
    exp_t e;
    logic done;
    e.we   = we;
    e.addr = a;
    e.data = we ? d : ref_rd(a);
    if (we) ref_m[a] = d;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    cur_addr      = a;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.cpu_ready) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL op_timeout addr=%h got=no_ready exp=ready", a);
      sbq.delete();
    end
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
  endtask

  int cyc, rf0, wb0, we0, k;
  logic [31:0] ra;

  initial begin
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    ok = !bus.cpu_ready && bus.cpu_rdata == 0 && !bus.mem_req &&
         !bus.mem_we && bus.mem_addr == 0 && bus.mem_wdata == 0 &&
         !we_cache && cache_addr == 0 && cache_data_in == 0 &&
         !set_valid && !set_dirty;
    check("reset_outputs", {31'h0, ok}, 32'h1);
`ifdef CACHE_STATS_EN
    check("reset_stats", hit_count | miss_count | wb_count, 32'h0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    flush = 1'b0;

    // Cold load
    mem_img[32'h41] = 32'hDEAD_BEEF;
    ref_m[32'h41]   = 32'hDEAD_BEEF;
    rf0 = n_rf; wb0 = n_wb; we0 = n_we;
    do_op(1'b0, 32'h41, 32'h0, cyc);
    check("cold_refills", n_rf - rf0, 1);
    check("cold_wbs", n_wb - wb0, 0);
    check("cold_we_pulses", n_we - we0, 1);

    // Store hit
    rf0 = n_rf;
    do_op(1'b1, 32'h41, 32'h1234_5678, cyc);
    check("store_hit_cycles", cyc, 1);
    check("store_hit_no_mem", n_rf - rf0, 0);

    // Dirty conflict miss
    wb0 = n_wb;
    do_op(1'b0, 32'h81, 32'h0, cyc);
    check("dirty_wb_count", n_wb - wb0, 1);
    check("dirty_wb_addr", last_wb_addr, 32'h41);
    check("dirty_wb_data", last_wb_data, 32'h1234_5678);
    check("dirty_refill_addr", last_rf_addr, 32'h81);

    // Clean conflict miss
    wb0 = n_wb; rf0 = n_rf;
    do_op(1'b0, 32'hC1, 32'h0, cyc);
    check("clean_no_wb", n_wb - wb0, 0);
    check("clean_refill", n_rf - rf0, 1);
`ifdef CACHE_STATS_EN
    check("stats_miss", miss_count, n_miss);
    check("stats_wb", wb_count, n_wb);
    check("stats_hit", hit_count, n_hit);
`endif

    // Stray mem_ready while idle
    mem_hold = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check("idle_ready_no_write", {30'h0, we_cache, bus.mem_req}, 32'h0);
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("idle_ready_stay", {30'h0, bus.mem_req, bus.cpu_ready}, 32'h0);
    mem_hold = 1'b0;
    do_op(1'b0, 32'hC1, 32'h0, cyc);
    check("idle_ready_then_hit", cyc, 1);

    // Reset during refill
    mem_hold = 1'b1;
    @(posedge clk);
    #1;
    cur_addr     = 32'h145;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h145;
    k = 0;
    while (!bus.mem_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("refill_started", {31'h0, bus.mem_req}, 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    flush = 1'b1;
    bus.cpu_req = 1'b0;
    sbq.delete();
    @(posedge clk);
    @(negedge clk);
    check("reset_mid_miss", {30'h0, bus.mem_req, bus.cpu_ready}, 32'h0);
    ref_m  = mem_img;
    n_hit  = 0;
    n_miss = 0;
    n_wb   = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    flush = 1'b0;
    mem_hold = 1'b0;
    fixed_lat = -1;

    // Random traffic on a 4x4 tag/index window
    for (int i = 0; i < 300; i++) begin
      ra = {22'h0, 4'($urandom_range(3, 0)), 6'($urandom_range(3, 0))};
      do_op(1'($urandom_range(1, 0)), ra, $urandom, cyc);
    end
`ifdef CACHE_STATS_EN
    check("final_hit_count", hit_count, n_hit);
    check("final_miss_count", miss_count, n_miss);
    check("final_wb_count", wb_count, n_wb);
`endif
    check("scoreboard_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
